// File: rtl/mealy_pkg.sv
// mealy_pkg: state codes and default counter width shared by the 1101 detector.
package mealy_pkg;
  localparam int CNT_W_DEF = 8;
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;
endpackage

// File: rtl/mealy_next_state.sv
// mealy_next_state: next-state function of the overlapping 1,1,0,1 detector.
module mealy_next_state
  import mealy_pkg::*;
(
  input  logic       w,
  input  logic [1:0] y,
  output logic [1:0] y_next
);
  always_comb begin
    y_next = (y == S2 && !w)           ? S3 :
             (y == S0 || y == S3)      ? (w ? S1 : S0) :
                                         (w ? S2 : S0);
  end
endmodule

// File: rtl/mealy_seq_ctrl.sv
// mealy_seq_ctrl: Mealy detector for 1,1,0,1 on w; MEALY_COUNT_EN adds a saturating det_count.
module mealy_seq_ctrl
  import mealy_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             w,
  input  logic             clr_count,
  output logic             z,
  output logic [1:0]       state
`ifdef MEALY_COUNT_EN
  ,
  output logic [CNT_W-1:0] det_count
`endif
);
  state_t     state_q, state_d;
  logic [1:0] y_next;
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end
  mealy_next_state u_next (
    .w      (w),
    .y      (state_q),
    .y_next (y_next)
  );
  always_comb begin
    state_d = en ? state_t'(y_next) : state_q;
    z       = en & w & (state_q == S3);
  end
  always_ff @(posedge clk) begin
    if (reset) state_q <= S0;
    else state_q <= state_d;
  end
  assign state = state_q;
`ifdef MEALY_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset || clr_count) det_count <= '0;
    else if (z && det_count != '1) det_count <= det_count + 1'b1;
  end
`else
  logic unused_clr;
  assign unused_clr = clr_count;
`endif
endmodule
